// File: rtl/sorter_seq.sv
// Sequential wrapper around the 8-lane, 8-bit combinational sorter.
// Collects eight bytes from a valid/ready stream into the sorter inputs,
// waits a programmable settle time, captures the sorted lanes and then
// streams them back out in ascending or descending order.

module sorter_seq #(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter int unsigned CNT_W         = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_data,
    input  logic             descend,
    input  logic             flush,
    output logic [63:0]      srt_a,
    input  logic [63:0]      srt_y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_data,
    output logic             out_last,
    output logic             busy,
    output logic [CNT_W-1:0] frames_done
);

    generate
        if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle
            $error("sorter_seq: SETTLE_CYCLES must lie in 1..15");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_LOAD   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_DRAIN  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [2:0]       cnt_q, cnt_d;
    logic [3:0]       settle_q, settle_d;
    logic [63:0]      srt_a_q, srt_a_d;
    logic [63:0]      y_q, y_d;
    logic             desc_q, desc_d;
    logic [CNT_W-1:0] frames_q, frames_d;
    logic             out_valid_q, out_valid_d;
    logic             out_last_q, out_last_d;
    logic [7:0]       out_data_q, out_data_d;
    logic             in_ready_q, in_ready_d;
    logic             busy_q, busy_d;
    logic             in_hs_s;
    logic             out_hs_s;
    logic [2:0]       idx_s;

    // Next-state logic for the frame FSM and the registered output stage.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        settle_d    = settle_q;
        srt_a_d     = srt_a_q;
        y_d         = y_q;
        desc_d      = desc_q;
        frames_d    = frames_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        out_data_d  = out_data_q;
        in_hs_s     = in_valid & in_ready_q;
        out_hs_s    = out_valid_q & out_ready;
        idx_s       = 3'd0;

        if (flush) begin
            // Abort wins over any handshake presented in the same cycle.
            state_d     = ST_LOAD;
            cnt_d       = 3'd0;
            settle_d    = 4'd0;
            out_valid_d = 1'b0;
        end else begin
            case (state_q)
                ST_LOAD: begin
                    out_valid_d = 1'b0;
                    if (in_hs_s) begin
                        srt_a_d[{cnt_q, 3'b000} +: 8] = in_data;
                        if (cnt_q == 3'd0) begin
                            desc_d = descend;
                        end else begin
                            desc_d = desc_q;
                        end
                        if (cnt_q == 3'd7) begin
                            state_d  = ST_SETTLE;
                            cnt_d    = 3'd0;
                            settle_d = 4'(SETTLE_CYCLES);
                        end else begin
                            cnt_d = cnt_q + 3'd1;
                        end
                    end else begin
                        cnt_d = cnt_q;
                    end
                end
                ST_SETTLE: begin
                    out_valid_d = 1'b0;
                    if (settle_q == 4'd1) begin
                        y_d      = srt_y;
                        state_d  = ST_DRAIN;
                        settle_d = 4'd0;
                    end else begin
                        settle_d = settle_q - 4'd1;
                    end
                end
                ST_DRAIN: begin
                    // out_valid comes up one cycle after entry, once y_q is loaded.
                    out_valid_d = 1'b1;
                    if (out_hs_s) begin
                        if (cnt_q == 3'd7) begin
                            state_d     = ST_LOAD;
                            cnt_d       = 3'd0;
                            frames_d    = frames_q + CNT_W'(1);
                            out_valid_d = 1'b0;
                        end else begin
                            cnt_d = cnt_q + 3'd1;
                        end
                    end else begin
                        cnt_d = cnt_q;
                    end
                end
                default: begin
                    state_d     = ST_LOAD;
                    cnt_d       = 3'd0;
                    settle_d    = 4'd0;
                    out_valid_d = 1'b0;
                end
            endcase
        end

        idx_s = desc_d ? (3'd7 - cnt_d) : cnt_d;
        if (out_valid_d) begin
            out_data_d = y_q[{idx_s, 3'b000} +: 8];
            out_last_d = (cnt_d == 3'd7);
        end else begin
            out_data_d = out_data_q;
            out_last_d = 1'b0;
        end

        in_ready_d = (state_d == ST_LOAD);
        busy_d     = !((state_d == ST_LOAD) && (cnt_d == 3'd0));
    end

    // State and output registers; async reset drops any frame in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_LOAD;
            cnt_q       <= 3'd0;
            settle_q    <= 4'd0;
            srt_a_q     <= 64'd0;
            y_q         <= 64'd0;
            desc_q      <= 1'b0;
            frames_q    <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= 8'd0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            settle_q    <= settle_d;
            srt_a_q     <= srt_a_d;
            y_q         <= y_d;
            desc_q      <= desc_d;
            frames_q    <= frames_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_data_q  <= out_data_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign srt_a       = srt_a_q;
    assign out_valid   = out_valid_q;
    assign out_data    = out_data_q;
    assign out_last    = out_last_q;
    assign busy        = busy_q;
    assign frames_done = frames_q;

    sorter_seq_chk u_chk (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_ready  (in_ready_q),
        .out_valid (out_valid_q),
        .out_last  (out_last_q),
        .cnt       (cnt_q)
    );

endmodule

// Simulation-only invariant checks for sorter_seq.
module sorter_seq_chk (
    input logic       clk,
    input logic       rst_n,
    input logic       in_ready,
    input logic       out_valid,
    input logic       out_last,
    input logic [2:0] cnt
);

    a_no_overlap: assert property (@(posedge clk) disable iff (!rst_n) !(in_ready && out_valid));
    a_cnt_range:  assert property (@(posedge clk) disable iff (!rst_n) cnt <= 3'd7);
    a_last_valid: assert property (@(posedge clk) disable iff (!rst_n) out_last |-> out_valid);

endmodule

// File: tb/tb_sorter_seq.sv
// Randomized self-checking bench for sorter_seq with a behavioural sorter
// model on srt_y and a queue-based reference for expected output order.

module tb_sorter_seq;

    localparam int SC = 2;
    localparam int CW = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [7:0]    in_data = 8'd0;
    logic          descend = 1'b0;
    logic          flush = 1'b0;
    logic [63:0]   srt_a;
    logic [63:0]   srt_y;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [7:0]    out_data;
    logic          out_last;
    logic          busy;
    logic [CW-1:0] frames_done;

    int            n_vec = 0;
    int            n_err = 0;
    logic [7:0]    lanes [8];
    int            mframes = 0;
    logic          mdesc = 1'b0;
    logic [7:0]    bb [8];

    sorter_seq #(.SETTLE_CYCLES(SC), .CNT_W(CW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .descend     (descend),
        .flush       (flush),
        .srt_a       (srt_a),
        .srt_y       (srt_y),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_last    (out_last),
        .busy        (busy),
        .frames_done (frames_done)
    );

    always #5 clk = ~clk;

    // Behavioural stand-in for the combinational sorter instance.
    function automatic logic [63:0] sorter(input logic [63:0] a);
        logic [7:0]  v [8];
        logic [7:0]  t;
        logic [63:0] r;
        for (int k = 0; k < 8; k++) v[k] = a[8*k +: 8];
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 7 - i; j++)
                if (v[j] > v[j+1]) begin
                    t = v[j]; v[j] = v[j+1]; v[j+1] = t;
                end
        r = 64'd0;
        for (int k = 0; k < 8; k++) r[8*k +: 8] = v[k];
        return r;
    endfunction

    assign srt_y = sorter(srt_a);

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [63:0] packed_lanes();
        logic [63:0] r;
        for (int k = 0; k < 8; k++) r[8*k +: 8] = lanes[k];
        return r;
    endfunction

    // mode 0: no gaps/backpressure; 1: fixed gap/toggle pattern; 2: random.
    // fl_in / fl_out: flush after that many accepted / drained bytes (8 = never).
    task automatic run_frame(input logic [7:0] b [8], input logic desc, input int mode,
                             input int fl_in, input int fl_out);
        logic [7:0] q [$];
        int i, cyc, lat, j, dc;
        logic hs;
        i = 0; cyc = 0;
        while (i < 8 && cyc < 200) begin
            chk("ld_in_ready", in_ready, 1);
            chk("ld_out_valid", out_valid, 0);
            if (i == fl_in) begin
                flush = 1'b1; in_valid = 1'b1; in_data = b[i];
                @(posedge clk); #1;
                flush = 1'b0; in_valid = 1'b0;
                chk("fl_in_ready", in_ready, 1);
                chk("fl_in_busy", busy, 0);
                chk("fl_in_srt_a", srt_a, packed_lanes());
                return;
            end
            case (mode)
                0:       in_valid = 1'b1;
                1:       in_valid = (cyc % 3 == 0);
                default: in_valid = 1'($urandom_range(0, 1));
            endcase
            in_data = b[i];
            descend = (i == 0) ? desc : ~desc;
            hs = in_valid & in_ready;
            @(posedge clk); #1;
            cyc++;
            if (hs) begin
                lanes[i] = b[i];
                if (i == 0) mdesc = desc;
                i++;
                if (i < 8) chk("ld_busy", busy, 1);
            end
        end
        in_valid = 1'b0;
        if (i < 8) begin
            chk("load_timeout", 64'(i), 64'd8);
            return;
        end
        chk("srt_a", srt_a, packed_lanes());
        lat = 0;
        while (!out_valid && lat < 20) begin
            chk("st_in_ready", in_ready, 0);
            @(posedge clk); #1;
            lat++;
        end
        chk("latency", 64'(lat), 64'(SC + 1));
        q = {};
        for (int k = 0; k < 8; k++) q.push_back(lanes[k]);
        q.sort();
        if (mdesc) q.reverse();
        j = 0; dc = 0;
        while (j < 8 && dc < 200) begin
            chk("dr_out_valid", out_valid, 1);
            chk("dr_in_ready", in_ready, 0);
            chk("dr_data", out_data, q[j]);
            chk("dr_last", out_last, (j == 7));
            if (j == fl_out) begin
                flush = 1'b1; out_ready = 1'b1;
                @(posedge clk); #1;
                flush = 1'b0; out_ready = 1'b0;
                chk("fl_out_valid", out_valid, 0);
                chk("fl_out_in_ready", in_ready, 1);
                chk("fl_out_frames", frames_done, 64'(mframes % 4));
                return;
            end
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = (dc % 2 == 0);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            hs = out_ready;
            @(posedge clk); #1;
            dc++;
            if (hs) j++;
        end
        out_ready = 1'b0;
        mframes++;
        chk("drain_count", 64'(j), 64'd8);
        if (mode == 0) chk("drain_cycles", 64'(dc), 64'd8);
        chk("end_out_valid", out_valid, 0);
        chk("end_out_last", out_last, 0);
        chk("end_in_ready", in_ready, 1);
        chk("end_busy", busy, 0);
        chk("frames", frames_done, 64'(mframes % 4));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < 8; k++) lanes[k] = 8'd0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_frames", frames_done, 0);
        chk("rst_srt_a", srt_a, 0);

        // Directed ascending frame with ties and extremes.
        run_frame('{8'h37, 8'h05, 8'hFF, 8'h00, 8'h80, 8'h12, 8'h12, 8'h7F}, 1'b0, 0, 8, 8);
        // Descend latched on first byte only (descend toggles afterwards).
        run_frame('{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08}, 1'b1, 0, 8, 8);
        for (int k = 0; k < 8; k++) bb[k] = 8'($urandom);
        run_frame(bb, 1'b0, 0, 8, 8);
        // Input gaps and output backpressure.
        for (int k = 0; k < 8; k++) bb[k] = 8'($urandom);
        run_frame(bb, 1'b1, 1, 8, 8);
        // Flush mid-load, then a frame of identical bytes.
        for (int k = 0; k < 8; k++) bb[k] = 8'($urandom);
        run_frame(bb, 1'b0, 0, 5, 8);
        run_frame('{8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'hAA}, 1'b0, 0, 8, 8);
        // Flush after the third output handshake.
        for (int k = 0; k < 8; k++) bb[k] = 8'($urandom);
        run_frame(bb, 1'b1, 0, 8, 3);

        // Async reset while in SETTLE.
        for (int k = 0; k < 8; k++) begin
            in_valid = 1'b1; in_data = 8'($urandom); descend = 1'b0;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("pre_rst_busy", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_out_valid", out_valid, 0);
        chk("arst_busy", busy, 0);
        chk("arst_frames", frames_done, 0);
        chk("arst_srt_a", srt_a, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) lanes[k] = 8'd0;
        mframes = 0;
        @(posedge clk); #1;

        // Random frames; frames_done wraps through 0 along the way.
        for (int f = 0; f < 6; f++) begin
            for (int k = 0; k < 8; k++) bb[k] = 8'($urandom_range(0, 15));
            run_frame(bb, 1'($urandom_range(0, 1)), (f < 2) ? 0 : 2, 8, 8);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
